// File: rtl/magnitude_pkg.sv
// magnitude_pkg: width helpers and pipeline constants shared by the magnitude_avg slice.
`default_nettype none

package magnitude_pkg;

  localparam int MAG_PIPE_LAT = 3;

  function automatic int acc_width(input int data_size, input int acc_log2_max);
    return 2 * data_size + acc_log2_max;
  endfunction

  function automatic int k_width(input int acc_log2_max);
    return $clog2(acc_log2_max + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/magnitude_sq.sv
// magnitude_sq: two-stage I*I + Q*Q with en/sof/eof carried alongside the data.
`default_nettype none

module magnitude_sq
  import magnitude_pkg::*;
#(
  parameter int DATA_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_SIZE-1:0]   smp_i,
  input  logic [DATA_SIZE-1:0]   smp_q,
  input  logic                   smp_en,
  input  logic                   smp_sof,
  input  logic                   smp_eof,
  output logic [2*DATA_SIZE-1:0] mag,
  output logic                   mag_en,
  output logic                   mag_sof,
  output logic                   mag_eof
);

  localparam int PW = 2 * DATA_SIZE;

  logic signed [PW-1:0] ext_i;
  logic signed [PW-1:0] ext_q;
  logic signed [PW-1:0] sq_i;
  logic signed [PW-1:0] sq_q;
  logic                 s1_en;
  logic                 s1_sof;
  logic                 s1_eof;

  // Sign-extend before multiplying so the full-width product is exact.
  assign ext_i = {{DATA_SIZE{smp_i[DATA_SIZE-1]}}, smp_i};
  assign ext_q = {{DATA_SIZE{smp_q[DATA_SIZE-1]}}, smp_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_i    <= '0;
      sq_q    <= '0;
      s1_en   <= 1'b0;
      s1_sof  <= 1'b0;
      s1_eof  <= 1'b0;
      mag     <= '0;
      mag_en  <= 1'b0;
      mag_sof <= 1'b0;
      mag_eof <= 1'b0;
    end else begin
      sq_i    <= ext_i * ext_i;
      sq_q    <= ext_q * ext_q;
      s1_en   <= smp_en;
      s1_sof  <= smp_sof;
      s1_eof  <= smp_eof;
      // Each square is at most 2^(2N-2), so the unsigned sum cannot wrap.
      mag     <= $unsigned(sq_i) + $unsigned(sq_q);
      mag_en  <= s1_en;
      mag_sof <= s1_sof;
      mag_eof <= s1_eof;
    end
  end

endmodule

`default_nettype wire

// File: rtl/magnitude_avg.sv
// magnitude_avg: I^2+Q^2 followed by a 2^k integrate-and-dump average, k chosen at run time.
// Define MAGNITUDE_AVG_ROUND_EN for round-half-up on the dump; otherwise the result is truncated.
`default_nettype none

module magnitude_avg
  import magnitude_pkg::*;
#(
  parameter int DATA_SIZE    = 16,
  parameter int ACC_LOG2_MAX = 8
) (
  input  logic                                data_clk_i,
  input  logic                                data_rst_i,
  input  logic [DATA_SIZE-1:0]                data_i_i,
  input  logic [DATA_SIZE-1:0]                data_q_i,
  input  logic                                data_en_i,
  input  logic                                data_sof_i,
  input  logic                                data_eof_i,
  input  logic [k_width(ACC_LOG2_MAX)-1:0]    acc_log2_i,
  output logic [2*DATA_SIZE-1:0]              data_o,
  output logic                                data_en_o,
  output logic                                data_sof_o,
  output logic                                data_eof_o,
  output logic                                data_rst_o,
  output logic                                data_clk_o
);

  localparam int DW    = 2 * DATA_SIZE;
  localparam int ACC_W = acc_width(DATA_SIZE, ACC_LOG2_MAX);
  localparam int KW    = k_width(ACC_LOG2_MAX);
  localparam int CNT_W = ACC_LOG2_MAX + 1;
`ifdef MAGNITUDE_AVG_ROUND_EN
  localparam int SUM_W = ACC_W + 1;
`else
  localparam int SUM_W = ACC_W;
`endif

  logic [DW-1:0]    mag;
  logic             mag_en;
  logic             mag_sof;
  logic             mag_eof;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [KW-1:0]    k_lat;
  logic             win_open;
  logic             sof_flag;
  logic             eof_flag;

  logic [KW-1:0]    k_new;
  logic [KW-1:0]    k_eff;
  logic             fresh;
  logic [CNT_W-1:0] cnt_eff;
  logic [ACC_W-1:0] acc_eff;
  logic [CNT_W-1:0] last_cnt;
  logic             dump;
  logic             sof_eff;
  logic             eof_eff;
  logic [SUM_W-1:0] base;
  logic [DW-1:0]    avg;

  assign data_rst_o = data_rst_i;
  assign data_clk_o = data_clk_i;

  magnitude_sq #(.DATA_SIZE(DATA_SIZE)) u_sq (
    .clk     (data_clk_i),
    .rst_n   (data_rst_i),
    .smp_i   (data_i_i),
    .smp_q   (data_q_i),
    .smp_en  (data_en_i),
    .smp_sof (data_sof_i),
    .smp_eof (data_eof_i),
    .mag     (mag),
    .mag_en  (mag_en),
    .mag_sof (mag_sof),
    .mag_eof (mag_eof)
  );

  // A sample opens a new window when none is open or when it carries sof;
  // the partial window is then dropped and k is taken fresh from the port.
  always_comb begin
    k_new    = (acc_log2_i > KW'(ACC_LOG2_MAX)) ? KW'(ACC_LOG2_MAX) : acc_log2_i;
    fresh    = mag_sof | ~win_open;
    k_eff    = fresh ? k_new : k_lat;
    cnt_eff  = fresh ? '0 : cnt;
    acc_eff  = fresh ? '0 : acc;
    sof_eff  = mag_sof | (~fresh & sof_flag);
    eof_eff  = mag_eof | (~fresh & eof_flag);
    last_cnt = (CNT_W'(1) << k_eff) - CNT_W'(1);
    dump     = (cnt_eff == last_cnt);
    base     = SUM_W'(acc_eff) + SUM_W'(mag);
`ifdef MAGNITUDE_AVG_ROUND_EN
    avg      = DW'((base + ((k_eff == '0) ? '0 : (SUM_W'(1) << (k_eff - KW'(1))))) >> k_eff);
`else
    avg      = DW'(base >> k_eff);
`endif
  end

  always_ff @(posedge data_clk_i or negedge data_rst_i) begin
    if (!data_rst_i) begin
      acc        <= '0;
      cnt        <= '0;
      k_lat      <= '0;
      win_open   <= 1'b0;
      sof_flag   <= 1'b0;
      eof_flag   <= 1'b0;
      data_o     <= '0;
      data_en_o  <= 1'b0;
      data_sof_o <= 1'b0;
      data_eof_o <= 1'b0;
    end else begin
      data_en_o  <= 1'b0;
      data_sof_o <= 1'b0;
      data_eof_o <= 1'b0;
      if (mag_en) begin
        if (dump) begin
          data_o     <= avg;
          data_en_o  <= 1'b1;
          data_sof_o <= sof_eff;
          data_eof_o <= eof_eff;
          win_open   <= 1'b0;
          acc        <= '0;
          cnt        <= '0;
          sof_flag   <= 1'b0;
          eof_flag   <= 1'b0;
        end else begin
          win_open   <= 1'b1;
          k_lat      <= k_eff;
          acc        <= base[ACC_W-1:0];
          cnt        <= cnt_eff + CNT_W'(1);
          sof_flag   <= sof_eff;
          eof_flag   <= eof_eff;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/magnitude_avg.md
Name: magnitude_avg

Overview:
- Pipelined, parametrised successor to the squared-magnitude stage: computes I²+Q² per complex sample, then block-averages 2^k consecutive magnitudes (integrate-and-dump) before output.
- k is selected at run time.
- Sits between DDC/FFT output and the spectrum/power-readout stages; uses the same data/en/sof/eof/clk/rst stream bus on input and output.

Parameters:
- DATA_SIZE, 16, width of signed I and Q inputs.
- ACC_LOG2_MAX, 8, maximum log2 of the averaging length; sets accumulator headroom.

Ports:
- data_clk_i  in  1  stream clock; sole clock.
- data_rst_i  in  1  asynchronous, active-low reset.
- data_i_i  in  DATA_SIZE  signed I sample.
- data_q_i  in  DATA_SIZE  signed Q sample.
- data_en_i  in  1  sample valid.
- data_sof_i  in  1  start of frame, qualified by data_en_i.
- data_eof_i  in  1  end of frame, qualified by data_en_i.
- acc_log2_i  in  $clog2(ACC_LOG2_MAX+1)  averaging exponent k.
- data_o  out  2*DATA_SIZE  unsigned averaged magnitude.
- data_en_o  out  1  output valid, one-cycle pulse per window.
- data_sof_o  out  1  first window of a frame.
- data_eof_o  out  1  window contained an eof.
- data_rst_o  out  1  = data_rst_i, passthrough.
- data_clk_o  out  1  = data_clk_i, passthrough.

Behaviour:
- Reset (data_rst_i low, async): all pipeline registers, accumulator, counter, latched k and flags clear; data_o=0, data_en_o=0, data_sof_o=0, data_eof_o=0. Release starts a fresh window.
- Stage 1: register signed I*I and Q*Q (2*DATA_SIZE bits each) with en/sof/eof.
- Stage 2: register unsigned sum, 2*DATA_SIZE bits. Max (-2^(N-1))²·2 = 2^(2N-1), so no overflow.
- Stage 3: accumulator of 2*DATA_SIZE+ACC_LOG2_MAX bits plus sample counter. Only valid (en) samples advance it; en gaps are allowed and ignored.
- Window start: latch k = min(acc_log2_i, ACC_LOG2_MAX).
  - acc_log2_i changes mid-window apply at the next window start.
- Dump, when the counter reaches 2^k-1 on a valid sample:
  - data_o = (acc + mag) >> k, truncated (see optional feature).
  - data_en_o=1 for one cycle.
  - Accumulator and counter clear.
  - New k is latched.
- k=0 is bypass: every sample dumps. Latency is 3 clocks from data_en_i to data_en_o.
- General latency: 3 clocks from the last sample of a window.
- sof on a valid sample: discard any partial window and start a new window with that sample, latching k. The dump of that window asserts data_sof_o.
- eof on any sample of a window: set a sticky flag; data_eof_o is asserted with that window's dump. eof does not force an early dump.
- sof and eof on the same sample: a window starts with sof flagged; eof is sticky for that window.
- data_sof_o and data_eof_o are meaningful only while data_en_o=1; 0 otherwise.
- Outputs hold their last value between dumps except en/sof/eof, which return to 0.

Optional Feature:
- MAGNITUDE_AVG_ROUND_EN defined: data_o = (acc + mag + 2^(k-1)) >> k (round half up; no rounding term when k=0). Sum width is one bit wider internally, so no overflow is possible.
- Undefined: plain truncation (floor).

Decomposition:
- magnitude_pkg holds:
  - the function computing accumulator width (2*DATA_SIZE+ACC_LOG2_MAX)
  - the k-port width function ($clog2(ACC_LOG2_MAX+1))
  - the stage-count constant MAG_PIPE_LAT=3
- One sub-module, magnitude_sq: stages 1–2 (squares and sum), carrying en/sof/eof alongside.
- Top level holds the window counter, accumulator, dump and flag logic.

Test Plan:
- k=0, I=3, Q=4, single en pulse -> 3 clocks later data_o=25, data_en_o high exactly 1 cycle.
- k=0, I=Q=-32768 -> data_o=0x80000000, no wrap.
- k=2, magnitudes 1,2,3,4 with en gaps between them -> one output, data_o=2 (10>>2). With MAGNITUDE_AVG_ROUND_EN -> 3.
- k=2, two samples, then sof on a sample with mag 8 followed by 3×mag 8 -> partial window discarded; single output 8 with data_sof_o=1. eof on the 4th sample -> data_eof_o=1 on the same output.
- k=2 mid-window, acc_log2_i changed to 1 -> current window still 4 samples; following windows 2 samples.
- Assert data_rst_i low mid-window (async, between clock edges) -> outputs 0 immediately. After release, a window of 2^k fresh samples is needed before the next data_en_o.
